// File: rtl/traffic_light_controller.sv
// traffic_light_controller: fixed-time two-road junction sequencer with flashing night mode; define TLC_BLINK_RED_EN to flash side red instead of side yellow
module traffic_light_controller #(
   parameter int unsigned CLK_HZ   = 100,
   parameter int unsigned T_MAIN_G = 30,
   parameter int unsigned T_SIDE_G = 20,
   parameter int unsigned T_YEL    = 5,
   parameter int unsigned T_RT     = 10,
   parameter int unsigned T_ALLRED = 2
) (
   input  logic clk,
   input  logic rst,
   output logic MG1,
   output logic MG2,
   output logic MR1,
   output logic MR2,
   output logic MY1,
   output logic MY2,
   output logic SG1,
   output logic SG2,
   output logic SR1,
   output logic SR2,
   output logic SY1,
   output logic SY2,
   output logic MRT1,
   output logic MRT2,
   output logic SRT1,
   output logic SRT2,
   input  logic blink
);
   typedef enum logic [2:0] {MAIN_GO, MAIN_YEL, MAIN_RT, ALLRED1, SIDE_GO, SIDE_YEL, SIDE_RT, ALLRED2} phase_t;
   localparam logic [31:0] LEN_MAIN_G = 32'(T_MAIN_G * CLK_HZ);
   localparam logic [31:0] LEN_SIDE_G = 32'(T_SIDE_G * CLK_HZ);
   localparam logic [31:0] LEN_YEL    = 32'(T_YEL * CLK_HZ);
   localparam logic [31:0] LEN_RT     = 32'(T_RT * CLK_HZ);
   localparam logic [31:0] LEN_ALLRED = 32'(T_ALLRED * CLK_HZ);
   localparam logic [31:0] HALF       = 32'(CLK_HZ / 2);
   logic        blink_meta_q, blink_sync_q;
   phase_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d, len;
   logic [31:0] flash_cnt_q, flash_cnt_d;
   logic        flash_q, flash_d;
   logic        hold, last, run;
   logic        mg_q, mr_q, my_q, sg_q, sr_q, sy_q, mrt_q, srt_q;
   logic        mg_d, mr_d, my_d, sg_d, sr_d, sy_d, mrt_d, srt_d;
   // two-flop synchroniser for the asynchronous blink request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_meta_q <= 1'b0;
         blink_sync_q <= 1'b0;
      end else begin
         blink_meta_q <= blink;
         blink_sync_q <= blink_meta_q;
      end
   end
   // phase register and its cycle counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ALLRED2;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // 1 Hz flash generator, restarted with the lamps on at each blink entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flash_q     <= 1'b0;
         flash_cnt_q <= '0;
      end else begin
         flash_q     <= flash_d;
         flash_cnt_q <= flash_cnt_d;
      end
   end
   // registered lamp drivers; reset shows all-red at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {mg_q, my_q, sg_q, sy_q, mrt_q, srt_q} <= '0;
         mr_q <= 1'b1;
         sr_q <= 1'b1;
      end else begin
         {mg_q, mr_q, my_q, sg_q, sr_q, sy_q, mrt_q, srt_q} <= {mg_d, mr_d, my_d, sg_d, sr_d, sy_d, mrt_d, srt_d};
      end
   end
   // next phase: hold in ALLRED2 while blink is seen at either sync stage so release gets a full all-red
   always_comb begin
      len = (state_q == MAIN_GO) ? LEN_MAIN_G :
            (state_q == SIDE_GO) ? LEN_SIDE_G :
            (state_q inside {MAIN_YEL, SIDE_YEL}) ? LEN_YEL :
            (state_q inside {MAIN_RT, SIDE_RT}) ? LEN_RT : LEN_ALLRED;
      hold = blink_meta_q | blink_sync_q;
      last = cnt_q == len - 32'd1;
      state_d = hold ? ALLRED2 : last ? phase_t'(state_q + 3'd1) : state_q;
      cnt_d = (hold || last) ? '0 : cnt_q + 32'd1;
      flash_cnt_d = (!blink_meta_q || !blink_sync_q || flash_cnt_q == HALF - 32'd1) ? '0 : flash_cnt_q + 32'd1;
      flash_d = !blink_meta_q ? 1'b0 : !blink_sync_q ? 1'b1 : (flash_cnt_q == HALF - 32'd1) ? ~flash_q : flash_q;
   end
   // lamp decode from the upcoming phase so lamps and phase register change on the same edge
   always_comb begin
      run   = !blink_meta_q;
      mg_d  = run && state_d == MAIN_GO;
      my_d  = run ? state_d == MAIN_YEL : flash_d;
      mrt_d = run && state_d == MAIN_RT;
      mr_d  = run && !(state_d inside {MAIN_GO, MAIN_YEL});
      sg_d  = run && state_d == SIDE_GO;
      srt_d = run && state_d == SIDE_RT;
`ifdef TLC_BLINK_RED_EN
      sy_d  = run && state_d == SIDE_YEL;
      sr_d  = run ? !(state_d inside {SIDE_GO, SIDE_YEL}) : flash_d;
`else
      sy_d  = run ? state_d == SIDE_YEL : flash_d;
      sr_d  = run && !(state_d inside {SIDE_GO, SIDE_YEL});
`endif
   end
   assign MG1  = mg_q;
   assign MG2  = mg_q;
   assign MR1  = mr_q;
   assign MR2  = mr_q;
   assign MY1  = my_q;
   assign MY2  = my_q;
   assign SG1  = sg_q;
   assign SG2  = sg_q;
   assign SR1  = sr_q;
   assign SR2  = sr_q;
   assign SY1  = sy_q;
   assign SY2  = sy_q;
   assign MRT1 = mrt_q;
   assign MRT2 = mrt_q;
   assign SRT1 = srt_q;
   assign SRT2 = srt_q;
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: random blink/reset stimulus against a time-based lamp model
module tb_traffic_light_controller;
   localparam int CLK_HZ = 100;
   localparam int CYCLE  = (2 + 30 + 5 + 10 + 2 + 20 + 5 + 10) * CLK_HZ;
   localparam logic [15:0] ALL_RED = 16'h30C0;
   localparam logic [15:0] GO_MAIN = 16'hC0C0;
   localparam logic [15:0] YEL_MAIN = 16'h0CC0;
`ifdef TLC_BLINK_RED_EN
   localparam logic [7:0]  BLINK_CODE = 8'h28;
   localparam logic [15:0] BLINK_ON   = 16'h0CC0;
`else
   localparam logic [7:0]  BLINK_CODE = 8'h24;
   localparam logic [15:0] BLINK_ON   = 16'h0C30;
`endif
   logic clk = 0;
   logic rst = 1;
   logic blink = 0;
   logic MG1, MG2, MR1, MR2, MY1, MY2, SG1, SG2, SR1, SR2, SY1, SY2, MRT1, MRT2, SRT1, SRT2;
   logic [15:0] act;
   int nvec = 0;
   int nerr = 0;
   // phases listed from the all-red that follows reset; lamp code bits {mg,mr,my,sg,sr,sy,mrt,srt}
   int dur [8] = '{2*CLK_HZ, 30*CLK_HZ, 5*CLK_HZ, 10*CLK_HZ, 2*CLK_HZ, 20*CLK_HZ, 5*CLK_HZ, 10*CLK_HZ};
   logic [7:0] codes [8] = '{8'h48, 8'h88, 8'h28, 8'h4A, 8'h48, 8'h50, 8'h44, 8'h49};
   bit [2:0] hist = '0;
   int m_t = 0;
   int m_fc = 0;

   traffic_light_controller dut (
      .clk(clk), .rst(rst),
      .MG1(MG1), .MG2(MG2), .MR1(MR1), .MR2(MR2), .MY1(MY1), .MY2(MY2),
      .SG1(SG1), .SG2(SG2), .SR1(SR1), .SR2(SR2), .SY1(SY1), .SY2(SY2),
      .MRT1(MRT1), .MRT2(MRT2), .SRT1(SRT1), .SRT2(SRT2),
      .blink(blink)
   );

   assign act = {MG1, MG2, MR1, MR2, MY1, MY2, SG1, SG2, SR1, SR2, SY1, SY2, MRT1, MRT2, SRT1, SRT2};

   always #5 clk = ~clk;

   // model: m_t is time into the all-red-first cycle, m_fc is time since blink became visible
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist <= '0;
         m_t  <= 0;
         m_fc <= 0;
      end else begin
         hist <= {hist[1:0], blink};
         if (hist[0]) begin
            m_fc <= hist[1] ? m_fc + 1 : 0;
            m_t  <= 0;
         end else if (!hist[1]) begin
            m_t <= (m_t + 1) % CYCLE;
         end
      end
   end

   function automatic logic [15:0] expect_lamps(input int tt, input bit vb, input int f);
      logic [7:0] code;
      logic [15:0] r;
      int acc;
      code = 8'h00;
      acc = 0;
      if (vb) begin
         code = ((f / (CLK_HZ / 2)) % 2 == 0) ? BLINK_CODE : 8'h00;
      end else begin
         for (int p = 0; p < 8; p++) begin
            if (tt >= acc && tt < acc + dur[p]) code = codes[p];
            acc += dur[p];
         end
      end
      for (int i = 0; i < 8; i++) r[2*i +: 2] = {2{code[i]}};
      return r;
   endfunction

   // every-cycle comparison against the model plus the safety invariant
   always @(negedge clk) begin
      logic [15:0] want;
      bit unsafe;
      want = expect_lamps(m_t, hist[1], m_fc);
      nvec++;
      if (act !== want) begin
         nerr++;
         $display("FAIL lamps t=%0d blink=%0b fc=%0d: got %h want %h", m_t, hist[1], m_fc, act, want);
      end
      if (!hist[1]) begin
         unsafe = ((MG1 | MY1 | MRT1) & (SG1 | SY1 | SRT1)) || ((MG2 | MY2 | MRT2) & (SG2 | SY2 | SRT2)) ||
                  $countones({MR1, MY1, MG1}) != 1 || $countones({MR2, MY2, MG2}) != 1 ||
                  $countones({SR1, SY1, SG1}) != 1 || $countones({SR2, SY2, SG2}) != 1;
         nvec++;
         if (unsafe) begin
            nerr++;
            $display("FAIL safety t=%0d: got %h want a conflict-free one-lamp-per-head set", m_t, act);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic wait_t(input int target);
      int n;
      n = 0;
      while (m_t != target && n < 2 * CYCLE) begin
         step();
         n++;
      end
      nvec++;
      if (m_t != target) begin
         nerr++;
         $display("FAIL wait_t: got t=%0d want t=%0d", m_t, target);
      end
   endtask

   initial begin
      #1 rst = 0;
      repeat (200) step();
      chk("reset_hold", act, ALL_RED);
      #1 rst = 1;
      repeat (199) step();
      chk("allred_before_go", act, ALL_RED);
      step();
      chk("main_go_start", act, GO_MAIN);
      repeat (3000) step();
      chk("main_yel_start", act, YEL_MAIN);
      repeat (2 * CYCLE - 3000) step();
      chk("main_go_after_two_cycles", act, GO_MAIN);
      wait_t(1000);
      #($urandom_range(1, 7)) blink = 1;
      repeat (3) step();
      chk("blink_on", act, BLINK_ON);
      repeat (50) step();
      chk("blink_off_phase", act, 16'h0000);
      repeat ($urandom_range(200, 600)) step();
      #($urandom_range(1, 7)) blink = 0;
      repeat (3) step();
      chk("blink_release_allred", act, ALL_RED);
      repeat (400) step();
      wait_t(5500);
      #2 rst = 0;
      #1 chk("async_rst", act, ALL_RED);
      repeat (5) step();
      #1 rst = 1;
      repeat (199) step();
      chk("rst_restart_allred", act, ALL_RED);
      step();
      chk("rst_restart_go", act, GO_MAIN);
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(50, 3000)) step();
         if ($urandom_range(0, 3) != 0) begin
            #($urandom_range(1, 7)) blink = 1;
            repeat ($urandom_range(1, 400)) step();
            #($urandom_range(1, 7)) blink = 0;
         end else begin
            #($urandom_range(1, 7)) rst = 0;
            repeat ($urandom_range(1, 10)) step();
            #($urandom_range(1, 7)) rst = 1;
         end
      end
      repeat (500) step();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
